// File: rtl/spi_master_link_pkg.sv
// Shared types and constants for the SPI master link: FSM states, opcodes
// and frame geometry.
package spi_master_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        TURN,
        RECV,
        GAP
    } state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int RSP_BITS   = 8;

endpackage

// File: rtl/spi_master_link_if.sv
// Host command/response port plus SPI pins of the SPI master link.
// The master modport is the link itself; slave is the host/pin side.
interface spi_master_link_if;
    import spi_master_link_pkg::*;

    logic                  cmd_valid;
    logic [FRAME_BITS-1:0] cmd_data;
    logic                  cmd_ready;
    logic                  rsp_valid;
    logic [RSP_BITS-1:0]   rsp_data;
    logic                  busy;
    logic                  SS_n;
    logic                  MOSI;
    logic                  MISO;

    modport master (
        input  cmd_valid, cmd_data, MISO,
        output cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );

    modport slave (
        output cmd_valid, cmd_data, MISO,
        input  cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );

endinterface

// File: rtl/spi_master_link_cmdbuf.sv
// One-entry command holding register used when SPI_MASTER_LINK_CMDBUF_EN
// is defined; filled while a frame runs, drained when the next frame starts.
module spi_master_link_cmdbuf
    import spi_master_link_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [FRAME_BITS-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic [FRAME_BITS-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload needs no reset; it is only ever read while full is set.
    always_ff @(posedge clk) begin
        if (push) begin
            data <= push_data;
        end
    end

endmodule

// File: rtl/spi_master_link.sv
// SPI master: serialises 10-bit command frames on MOSI and collects the
// 8-bit reply of rd-data frames. Optional buffer: SPI_MASTER_LINK_CMDBUF_EN.
module spi_master_link
    import spi_master_link_pkg::*;
#(
    parameter int TURN_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input logic               clk,
    input logic               rst_n,
    spi_master_link_if.master bus
);

    if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
        $error("TURN_CYCLES must be in 1..15");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("GAP_CYCLES must be in 1..15");
    end

    localparam logic [3:0] TURN_LOAD  = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] SHIFT_LOAD = 4'(FRAME_BITS - 1);
    localparam logic [3:0] RECV_LOAD  = 4'(RSP_BITS - 1);

    state_t                state, state_nxt;
    logic [FRAME_BITS-1:0] shreg;
    logic [3:0]            bit_cnt;
    logic [3:0]            tg_cnt;
    logic [RSP_BITS-2:0]   rsp_shreg;
    logic [RSP_BITS-1:0]   rsp_data;
    logic                  rsp_valid;
    logic                  accept;
    logic                  load;
    logic [FRAME_BITS-1:0] load_data;
    logic                  buf_full;
    logic [FRAME_BITS-1:0] buf_data;
    logic                  ss_n;
    logic                  mosi;

    assign accept = bus.cmd_valid && bus.cmd_ready;

`ifdef SPI_MASTER_LINK_CMDBUF_EN
    logic push;
    logic pop;

    // In IDLE with an empty buffer the command goes straight to START.
    assign push = accept && (state != IDLE);
    assign pop  = load && buf_full;

    spi_master_link_cmdbuf u_cmdbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.cmd_data),
        .pop       (pop),
        .full      (buf_full),
        .data      (buf_data)
    );

    assign bus.cmd_ready = rst_n && !buf_full;
`else
    assign buf_full      = 1'b0;
    assign buf_data      = '0;
    assign bus.cmd_ready = rst_n && (state == IDLE);
`endif

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_data = bus.cmd_data;
        unique case (state)
            IDLE: begin
                if (buf_full) begin
                    state_nxt = START;
                    load      = 1'b1;
                    load_data = buf_data;
                end else if (accept) begin
                    state_nxt = START;
                    load      = 1'b1;
                end
            end
            START: state_nxt = SHIFT;
            SHIFT: begin
                if (bit_cnt == 4'd0) begin
                    state_nxt = (shreg[9:8] == OP_RD_DATA) ? TURN : GAP;
                end
            end
            TURN: if (tg_cnt == 4'd0) state_nxt = RECV;
            RECV: if (bit_cnt == 4'd0) state_nxt = GAP;
            GAP: begin
                if (tg_cnt == 4'd0) begin
                    if (buf_full) begin
                        state_nxt = START;
                        load      = 1'b1;
                        load_data = buf_data;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            tg_cnt    <= '0;
            rsp_shreg <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            if (load) shreg <= load_data;
            case (state)
                START: bit_cnt <= SHIFT_LOAD;
                SHIFT: begin
                    if (bit_cnt == 4'd0) begin
                        tg_cnt <= (state_nxt == TURN) ? TURN_LOAD : GAP_LOAD;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                TURN: begin
                    if (tg_cnt == 4'd0) bit_cnt <= RECV_LOAD;
                    else                tg_cnt  <= tg_cnt - 4'd1;
                end
                RECV: begin
                    rsp_shreg <= {rsp_shreg[RSP_BITS-3:0], bus.MISO};
                    if (bit_cnt == 4'd0) begin
                        rsp_data  <= {rsp_shreg, bus.MISO};
                        rsp_valid <= 1'b1;
                        tg_cnt    <= GAP_LOAD;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                GAP: if (tg_cnt != 4'd0) tg_cnt <= tg_cnt - 4'd1;
                default: ;
            endcase
        end
    end

    // START repeats the command bit ahead of the full MSB-first word.
    always_comb begin
        ss_n = 1'b1;
        mosi = 1'b0;
        case (state)
            START: begin
                ss_n = 1'b0;
                mosi = shreg[FRAME_BITS-1];
            end
            SHIFT: begin
                ss_n = 1'b0;
                mosi = shreg[bit_cnt];
            end
            TURN, RECV: ss_n = 1'b0;
            default: ;
        endcase
    end

    assign bus.SS_n      = ss_n;
    assign bus.MOSI      = mosi;
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;

endmodule

// File: tb/tb_spi_master_link.sv
// Self-checking bench for spi_master_link: directed cases plus random
// commands checked against a frame-level model of the SPI link.
module tb_spi_master_link;
    import spi_master_link_pkg::*;

    localparam int TURN    = 2;
    localparam int GAP     = 1;
    localparam int LEN_WR  = FRAME_BITS + 1;
    localparam int RX_FROM = FRAME_BITS + 1 + TURN;
    localparam int LEN_RD  = RX_FROM + RSP_BITS;
`ifdef SPI_MASTER_LINK_CMDBUF_EN
    localparam int MIN_HIGH = GAP;
`else
    localparam int MIN_HIGH = GAP + 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_master_link_if bus ();

    spi_master_link #(
        .TURN_CYCLES (TURN),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level model state: accepted commands in order, current frame capture.
    logic [9:0]  exp_q[$];
    int          low_cnt     = 0;
    int          high_cnt    = 99;
    int          frame_gap   = 0;
    int          last_len    = 0;
    int          frames_done = 0;
    int          rsp_count   = 0;
    logic [31:0] frame_bits  = '0;
    logic [31:0] last_bits   = '0;
    logic [9:0]  last_cmd    = '0;
    logic [7:0]  cur_reply   = '0;
    logic [7:0]  last_rsp    = '0;
    logic [7:0]  forced_reply = '0;
    bit          use_forced  = 1'b0;
    bit          aborted     = 1'b0;

    task automatic end_frame();
        logic [9:0]  c;
        logic [31:0] exp_bits;
        last_len  = low_cnt;
        last_bits = frame_bits;
        frames_done++;
        high_cnt  = 0;
        if (exp_q.size() == 0) begin
            check("frame_unexpected", 1, 0);
            return;
        end
        c = exp_q.pop_front();
        if (aborted) begin
            aborted = 1'b0;
            check("abort_no_rsp", bus.rsp_valid, 0);
            return;
        end
        last_cmd = c;
        exp_bits = {21'b0, c[9], c};
        if (c[9:8] == OP_RD_DATA) begin
            check("frame_len_rd", low_cnt, LEN_RD);
            check("frame_mosi_rd", frame_bits >> RSP_BITS, exp_bits << TURN);
            check("rsp_valid", bus.rsp_valid, 1);
            check("rsp_data", bus.rsp_data, cur_reply);
        end else begin
            check("frame_len_wr", low_cnt, LEN_WR);
            check("frame_mosi_wr", frame_bits, exp_bits);
            check("rsp_none_wr", bus.rsp_valid, 0);
        end
    endtask

    // Monitor and slave model, sampling mid-cycle on the falling edge.
    always @(negedge clk) begin
        bit ended;
        int n;
        ended = 1'b0;
        if (rst_n && bus.cmd_valid && bus.cmd_ready === 1'b1) exp_q.push_back(bus.cmd_data);
        if (!rst_n) begin
            if (low_cnt > 0) aborted = 1'b1;
            high_cnt = 99;
        end
        if (bus.rsp_valid === 1'b1) begin
            rsp_count++;
            last_rsp = bus.rsp_data;
        end
        if (bus.SS_n === 1'b0) begin
            if (low_cnt == 0) begin
                frame_gap = high_cnt;
                if (high_cnt < 99) check("min_gap", (high_cnt >= MIN_HIGH), 1);
                cur_reply  = use_forced ? forced_reply : 8'($urandom);
                frame_bits = '0;
            end
            frame_bits = {frame_bits[30:0], bus.MOSI};
            n = low_cnt;
            low_cnt++;
            if (n >= RX_FROM && n < LEN_RD) bus.MISO = cur_reply[7 - (n - RX_FROM)];
            else                            bus.MISO = 1'($urandom);
        end else begin
            bus.MISO = 1'($urandom);
            if (low_cnt > 0) begin
                end_frame();
                ended = 1'b1;
            end
            if (high_cnt < 99) high_cnt++;
            low_cnt = 0;
        end
        if (!ended && bus.rsp_valid === 1'b1) check("rsp_spurious", 1, 0);
    end

    task automatic send(input logic [9:0] c);
        bit acc;
        acc = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = c;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            acc = (bus.cmd_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 0, 1);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 10'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy !== 1'b0 || exp_q.size() != 0) && n < 600);
        if (n >= 600) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int fd0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_ss_n", bus.SS_n, 1);
            check("rst_cmd_ready", bus.cmd_ready, 0);
            check("rst_rsp_valid", bus.rsp_valid, 0);
        end
        check("rst_busy", bus.busy, 0);
        check("rst_mosi", bus.MOSI, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", bus.cmd_ready, 1);
        @(posedge clk);
        #1;

        // Write-address frame
        send(10'h0A5);
        wait_idle();
        check("wr_addr_len", last_len, 11);
        check("wr_addr_mosi", last_bits, 32'h0A5);

        // Read-data frame with a fixed reply
        rc0          = rsp_count;
        use_forced   = 1'b1;
        forced_reply = 8'hC3;
        send(10'h3FF);
        @(negedge clk);
        check("busy_in_frame", bus.busy, 1);
`ifdef SPI_MASTER_LINK_CMDBUF_EN
        check("ready_in_frame", bus.cmd_ready, 1);
`else
        check("ready_in_frame", bus.cmd_ready, 0);
`endif
        wait_idle();
        use_forced = 1'b0;
        check("rd_data_len", last_len, 21);
        check("rd_data_rsp", last_rsp, 8'hC3);
        check("rd_data_pulses", rsp_count - rc0, 1);

        // Back-to-back frames with cmd_valid held high
        send(10'h155);
        send(10'h2AA);
        wait_idle();
        check("b2b_gap", frame_gap, MIN_HIGH);
        check("b2b_cmd", last_cmd, 10'h2AA);
        check("b2b_mosi", last_bits, 32'h6AA);

        // Reset during SHIFT with bit counter at 4
        rc0 = rsp_count;
        send(10'h1C7);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_ss_n", bus.SS_n, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(10'h2F0);
        wait_idle();
        check("post_abort_len", last_len, 11);
        check("post_abort_mosi", last_bits, 32'h6F0);
        check("abort_pulses", rsp_count - rc0, 0);

`ifdef SPI_MASTER_LINK_CMDBUF_EN
        // Buffered command mid-frame, third command stalls until drain
        send(10'h3A1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        fd0           = frames_done;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 10'h0B2;
        @(negedge clk);
        check("buf_accept", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        bus.cmd_data = 10'h163;
        @(negedge clk);
        check("buf_full_stall", bus.cmd_ready, 0);
        send(10'h163);
        check("buf_drain_point", frames_done - fd0, 1);
        wait_idle();
        check("buf_gap", frame_gap, GAP);
        check("buf_last_mosi", last_bits, 32'h163);
`else
        fd0 = frames_done;
        rc0 = 0;
`endif

        // Random commands with random spacing
        for (int k = 0; k < 40; k++) begin
            send(10'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
            end else begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_idle();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_ss_n", bus.SS_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
